// File: rtl/instr_register_pkg.sv
// Shared instruction register types: opcode set, signed operands and the packed instruction word.
package instr_register_pkg;

  localparam int DEPTH = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage

// File: rtl/instr_exec_if.sv
// Control, register-file read port and result handshake of the execution stage.
interface instr_exec_if #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
);

  logic                            start;
  logic [IDX_W-1:0]                start_index;
  logic [CNT_W-1:0]                count;
  logic                            busy;
  logic                            done;
  logic [IDX_W-1:0]                read_index;
  instr_register_pkg::instruction_t instruction;
  logic                            res_valid;
  logic                            res_ready;
  logic [IDX_W-1:0]                res_index;
  instr_register_pkg::opcode_t     res_opc;
  logic signed [63:0]              result;
  logic                            res_err;

  // master: controller / register file / result consumer side
  modport master (
    output start, start_index, count, instruction, res_ready,
    input  busy, done, read_index, res_valid, res_index, res_opc, result, res_err
  );

  modport slave (
    input  start, start_index, count, instruction, res_ready,
    output busy, done, read_index, res_valid, res_index, res_opc, result, res_err
  );

endinterface

// File: rtl/instr_exec_unit.sv
// Walks a contiguous range of instruction register entries, evaluates each one and
// hands one signed 64-bit result per entry to a valid/ready consumer.
module instr_exec_unit #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          reset_en,
  instr_exec_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                       state_reg;
  logic [IDX_W-1:0]                 read_index_reg;
  logic [CNT_W-1:0]                 remaining_reg;
  instr_register_pkg::instruction_t instr_reg;
  logic                             busy_reg;
  logic                             done_reg;
  logic                             res_valid_reg;
  logic [IDX_W-1:0]                 res_index_reg;
  instr_register_pkg::opcode_t      res_opc_reg;
  logic signed [63:0]               result_reg;
  logic                             res_err_reg;

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] result_next;
  logic               err_next;
  logic [IDX_W-1:0]   read_index_next;

  // Operands are widened before any operation so products and quotients are exact.
  always_comb begin
    a_ext       = {{32{instr_reg.op_a[31]}}, instr_reg.op_a};
    b_ext       = {{32{instr_reg.op_b[31]}}, instr_reg.op_b};
    result_next = '0;
    err_next    = 1'b0;
    case (instr_reg.opc)
      instr_register_pkg::ZERO:  result_next = '0;
      instr_register_pkg::PASSA: result_next = a_ext;
      instr_register_pkg::PASSB: result_next = b_ext;
      instr_register_pkg::ADD:   result_next = a_ext + b_ext;
      instr_register_pkg::SUB:   result_next = a_ext - b_ext;
      instr_register_pkg::MULT:  result_next = a_ext * b_ext;
      instr_register_pkg::DIV: begin
        if (b_ext == '0) err_next = 1'b1;
        else             result_next = a_ext / b_ext;
      end
      instr_register_pkg::MOD: begin
        if (b_ext == '0) err_next = 1'b1;
        else             result_next = a_ext % b_ext;
      end
      default:           err_next = 1'b1;
    endcase
  end

  always_comb begin
    if (read_index_reg == IDX_W'(DEPTH - 1)) read_index_next = '0;
    else                                     read_index_next = read_index_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_en) begin
    if (!reset_en) begin
      state_reg      <= S_IDLE;
      read_index_reg <= '0;
      remaining_reg  <= '0;
      instr_reg      <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_index_reg  <= '0;
      res_opc_reg    <= instr_register_pkg::ZERO;
      result_reg     <= '0;
      res_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start && (bus.count != '0)) begin
            read_index_reg <= bus.start_index;
            remaining_reg  <= bus.count;
            busy_reg       <= 1'b1;
            state_reg      <= S_FETCH;
          end
        end
        S_FETCH: begin
          instr_reg <= bus.instruction;
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          result_reg    <= result_next;
          res_err_reg   <= err_next;
          res_opc_reg   <= instr_reg.opc;
          res_index_reg <= read_index_reg;
          res_valid_reg <= 1'b1;
          state_reg     <= S_OUT;
        end
        S_OUT: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == CNT_W'(1)) begin
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              read_index_reg <= read_index_next;
              state_reg      <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.read_index = read_index_reg;
  assign bus.res_valid  = res_valid_reg;
  assign bus.res_index  = res_index_reg;
  assign bus.res_opc    = res_opc_reg;
  assign bus.result     = result_reg;
  assign bus.res_err    = res_err_reg;

endmodule
